// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I load/store funct3 codes and LSU FSM state encoding
package riscv_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    // Stores have no unsigned variants, so any funct3 with bit 2 set is illegal for them.
    function automatic logic funct3_illegal(input logic we, input logic [2:0] funct3);
        if (we)
            return funct3[2] || (funct3[1:0] == 2'b11);
        else
            return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// rtl/lsu_data_align.sv - byte-enable generation, store lane replication, load extraction/extension
module lsu_data_align
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       funct3,
    input  logic [1:0]       offset,
    input  logic [WIDTH-1:0] store_data,
    input  logic [WIDTH-1:0] raw_data,
    output logic [3:0]       be,
    output logic [WIDTH-1:0] lane_data,
    output logic [WIDTH-1:0] load_data
);

    logic [WIDTH-1:0] shifted;

    always_comb begin
        be        = 4'b1111;
        lane_data = store_data;
        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << offset;
                lane_data = {4{store_data[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << offset;
                lane_data = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Offset is already aligned down for halves and words, so a plain shift picks the lane.
    always_comb begin
        shifted   = raw_data >> {offset, 3'b000};
        load_data = shifted;
        case (funct3)
            LB:      load_data = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
            LH:      load_data = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
            LBU:     load_data = {{(WIDTH-8){1'b0}}, shifted[7:0]};
            LHU:     load_data = {{(WIDTH-16){1'b0}}, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit; LSU_MISALIGN_CHECK_EN turns misalignment into a fault
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic             mem_req,
    output logic             mem_we,
    output logic [3:0]       mem_be,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata
);

    logic [1:0]       state;
    logic             lat_we;
    logic [2:0]       lat_funct3;
    logic [1:0]       lat_offset;
    logic [WIDTH-1:0] lat_wdata;

    logic             misaligned;
    logic             illegal;
    logic [1:0]       req_offset;
    logic [3:0]       be;
    logic [WIDTH-1:0] lane_data;
    logic [WIDTH-1:0] load_data;

    always_comb begin
        misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_CHECK_EN
        illegal = funct3_illegal(req_we, req_funct3) || misaligned;
`else
        illegal = funct3_illegal(req_we, req_funct3);
`endif
        // Without the fault check, misaligned halves/words silently drop the low address bits.
        case (req_funct3[1:0])
            2'b01:   req_offset = {req_addr[1], 1'b0};
            2'b10:   req_offset = 2'b00;
            default: req_offset = req_addr[1:0];
        endcase
    end

    lsu_data_align #(.WIDTH(WIDTH)) u_align (
        .funct3     (lat_funct3),
        .offset     (lat_offset),
        .store_data (lat_wdata),
        .raw_data   (mem_rdata),
        .be         (be),
        .lane_data  (lane_data),
        .load_data  (load_data)
    );

    assign req_ready = (state == ST_IDLE);
    assign mem_req   = (state == ST_REQ);
    assign mem_we    = mem_req && lat_we;
    assign mem_be    = mem_req ? be : 4'b0000;
    assign mem_wdata = mem_req ? lane_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            lat_we     <= 1'b0;
            lat_funct3 <= 3'b000;
            lat_offset <= 2'b00;
            lat_wdata  <= '0;
            mem_addr   <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_we     <= req_we;
                        lat_funct3 <= req_funct3;
                        lat_offset <= req_offset;
                        lat_wdata  <= req_wdata;
                        if (illegal) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state    <= ST_REQ;
                            mem_addr <= {req_addr[WIDTH-1:2], 2'b00};
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_gnt)
                        state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= lat_we ? '0 : load_data;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks;
    int errors;

    load_store_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_access(input string tag, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int gnt_delay,
                              input logic [31:0] exp_addr, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        tick();
        req_valid = 1'b0; req_wdata = 32'h5A5A_5A5A;
        check({tag, ".mem_req"}, 32'(mem_req), 32'd1);
        check({tag, ".mem_we"}, 32'(mem_we), 32'(we));
        check({tag, ".mem_be"}, 32'(mem_be), 32'(exp_be));
        check({tag, ".mem_addr"}, mem_addr, exp_addr);
        if (we) check({tag, ".mem_wdata"}, mem_wdata, exp_wdata);
        for (int i = 0; i < gnt_delay; i++) begin
            mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
            tick();
            check({tag, ".hold_req"}, 32'(mem_req), 32'd1);
            check({tag, ".hold_addr"}, mem_addr, exp_addr);
            check({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
            check({tag, ".hold_noresp"}, 32'(resp_valid), 32'd0);
        end
        mem_rvalid = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check({tag, ".wait_noreq"}, 32'(mem_req), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = rdata;
        tick();
        mem_rvalid = 1'b0;
        check({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, ".resp_err"}, 32'(resp_err), 32'd0);
        check({tag, ".resp_rdata"}, resp_rdata, exp_rdata);
        tick();
        check({tag, ".resp_pulse"}, 32'(resp_valid), 32'd0);
        check({tag, ".idle"}, 32'(req_ready), 32'd1);
    endtask

    task automatic run_illegal(input string tag, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = 32'hFFFF_FFFF;
        tick();
        req_valid = 1'b0;
        check({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, ".resp_err"}, 32'(resp_err), 32'd1);
        check({tag, ".resp_rdata"}, resp_rdata, 32'd0);
        check({tag, ".no_mem_req"}, 32'(mem_req), 32'd0);
        tick();
        check({tag, ".resp_pulse"}, 32'(resp_valid), 32'd0);
        check({tag, ".no_mem_req2"}, 32'(mem_req), 32'd0);
        check({tag, ".idle"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        tick();
        tick();
        check("rst.ready", 32'(req_ready), 32'd1);
        check("rst.mem_req", 32'(mem_req), 32'd0);
        check("rst.mem_we", 32'(mem_we), 32'd0);
        check("rst.mem_be", 32'(mem_be), 32'd0);
        check("rst.mem_addr", mem_addr, 32'd0);
        check("rst.mem_wdata", mem_wdata, 32'd0);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.resp_err", 32'(resp_err), 32'd0);
        check("rst.resp_rdata", resp_rdata, 32'd0);
        rst = 1'b0;
        tick();

        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_AAAA;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        check("idle_ignore.resp", 32'(resp_valid), 32'd0);
        check("idle_ignore.req", 32'(mem_req), 32'd0);

        run_access("lw",  1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 32'h100, 4'b1111, 32'h0, 32'hDEAD_BEEF);
        run_access("lb",  1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_7F01, 0, 32'h100, 4'b1000, 32'h0, 32'hFFFF_FF80);
        run_access("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_7F01, 0, 32'h100, 4'b1000, 32'h0, 32'h0000_0080);
        run_access("lh",  1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF_7F01, 0, 32'h100, 4'b1100, 32'h0, 32'hFFFF_80FF);
        run_access("lhu", 1'b0, 3'b101, 32'h200, 32'h0, 32'h80FF_7F01, 0, 32'h200, 4'b0011, 32'h0, 32'h0000_7F01);
        run_access("sh",  1'b1, 3'b001, 32'h102, 32'h0000_ABCD, 32'h1234_5678, 0, 32'h100, 4'b1100, 32'hABCD_ABCD, 32'h0);
        run_access("sb",  1'b1, 3'b000, 32'h301, 32'h1234_5678, 32'h0, 0, 32'h300, 4'b0010, 32'h7878_7878, 32'h0);
        run_access("sw_gnt3", 1'b1, 3'b010, 32'h400, 32'hCAFE_F00D, 32'h0, 3, 32'h400, 4'b1111, 32'hCAFE_F00D, 32'h0);

        run_illegal("ld_f3_011", 1'b0, 3'b011, 32'h100);
        run_illegal("st_f3_100", 1'b1, 3'b100, 32'h100);
`ifdef LSU_MISALIGN_CHECK_EN
        run_illegal("lw_misalign", 1'b0, 3'b010, 32'h101);
        run_illegal("lh_misalign", 1'b0, 3'b001, 32'h103);
`else
        run_access("lw_misalign", 1'b0, 3'b010, 32'h101, 32'h0, 32'h0BAD_F00D, 0, 32'h100, 4'b1111, 32'h0, 32'h0BAD_F00D);
        run_access("lh_misalign", 1'b0, 3'b001, 32'h103, 32'h0, 32'h8001_7F01, 0, 32'h100, 4'b1100, 32'h0, 32'hFFFF_8001);
`endif

        // Abort a load in WAIT with reset, then deliver a stale rvalid.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h500;
        tick();
        req_valid = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("abort.in_wait", 32'(mem_req), 32'd0);
        check("abort.busy", 32'(req_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort.ready", 32'(req_ready), 32'd1);
        check("abort.mem_req", 32'(mem_req), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        tick();
        mem_rvalid = 1'b0;
        check("abort.no_resp", 32'(resp_valid), 32'd0);
        check("abort.still_idle", 32'(req_ready), 32'd1);
        tick();
        check("abort.no_resp2", 32'(resp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
